multicycle_ctrl: RTL and testbench

//  Control sequencer for the 32-bit multicycle MIPS datapath: a Moore FSM (plus ready-qualified strobes) that steps

---
 rtl/mips_pkg.sv | 112 +++++++++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multicycle_ctrl.sv | 122 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, state encoding,
// datapath select codes and the per-state Moore control decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  // fetch_strobe marks the state whose ir_write/pc_write follow mem_ready
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch_strobe;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic ctl_t ctrl_decode(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read     = 1'b1;
        c.fetch_strobe = 1'b1;
        c.alu_src_b    = SRCB_FOUR;
        c.alu_op       = ALUOP_ADD;
        c.pc_source    = PCSRC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_BRANCH;
      S_MEM_ADDR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of a pending memory access and flags the cycle in which the
// count reaches the timeout limit (TIMEOUT = 0 disables the watchdog).
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // saturating wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // expires on the cycle whose miss would bring the count up to TIMEOUT
  assign expire = (TIMEOUT != 0) && (cnt_r >= LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: registered Moore decode per state, with
// mem_ready-qualified fetch strobes, zero-qualified branch PC write and a memory watchdog.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       err,
  output logic [3:0] state
);

  state_e state_r;
  state_e next_s;
  ctl_t   ctl_r;
  logic   err_r;
  logic   err_set_s;
  logic   in_mem_s;
  logic   hold_s;
  logic   abort_s;
  logic   expire_s;

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~hold_s),
    .inc    (hold_s),
    .expire (expire_s)
  );

  // memory-wait qualification; a ready in the expiry cycle completes the access
  always_comb begin
    in_mem_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    abort_s  = in_mem_s && expire_s && !mem_ready;
    hold_s   = in_mem_s && !mem_ready && !abort_s;
  end

  // next-state selection
  always_comb begin
    next_s    = state_r;
    err_set_s = 1'b0;
    if (abort_s) begin
      next_s    = S_FETCH;
      err_set_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE:     next_s = S_FETCH;
        S_FETCH:    next_s = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_RTYPE:     next_s = S_EXEC_R;
            OP_LW, OP_SW: next_s = S_MEM_ADDR;
            OP_BEQ:       next_s = S_BRANCH;
            OP_ADDI:      next_s = S_ADDI_EX;
            OP_J:         next_s = S_JUMP;
            default: begin
              next_s    = S_FETCH;
              err_set_s = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: next_s = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   next_s = mem_ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   next_s = mem_ready ? S_FETCH : S_MEM_WR;
        S_EXEC_R:   next_s = S_R_WB;
        S_ADDI_EX:  next_s = S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: next_s = S_FETCH;
        default:    next_s = S_IDLE;
      endcase
    end
  end

  // state, registered Moore controls for the coming state, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ctl_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      ctl_r   <= ctrl_decode(next_s);
      err_r   <= err_r | err_set_s;
    end
  end

  assign mem_read   = ctl_r.mem_read & ~abort_s;
  assign mem_write  = ctl_r.mem_write & ~abort_s;
  assign ir_write   = ctl_r.fetch_strobe & mem_ready;
  assign pc_en      = (ctl_r.fetch_strobe & mem_ready) | ctl_r.pc_write |
                      (ctl_r.pc_write_cond & zero);
  assign iord       = ctl_r.iord;
  assign mem_to_reg = ctl_r.mem_to_reg;
  assign reg_dst    = ctl_r.reg_dst;
  assign reg_write  = ctl_r.reg_write;
  assign alu_src_a  = ctl_r.alu_src_a;
  assign alu_src_b  = ctl_r.alu_src_b;
  assign alu_op     = ctl_r.alu_op;
  assign pc_source  = ctl_r.pc_source;
  assign err        = err_r;
  assign state      = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: an instruction-level model expands each instruction into its
// expected per-cycle state/output trace, which is compared against the DUT.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, err;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .err(err), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic err, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       ready;
    logic       zero;
    obs_t       exp;
  } rec_t;

  rec_t plan[$];
  obs_t seen[$];
  int   checks = 0;
  int   errors = 0;
  logic m_err = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o = {state, err, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
         reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    return o;
  endfunction

  // what each step of an instruction drives, from the control table
  function automatic obs_t exp_out(state_e p, logic r, logic z, logic a, logic e);
    obs_t o;
    o = '0;
    o.st  = p;
    o.err = e;
    case (p)
      S_FETCH: begin
        o.mem_read = ~a; o.alu_src_b = 2'b01; o.ir_write = r; o.pc_en = r;
      end
      S_DECODE:   o.alu_src_b = 2'b11;
      S_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      S_MEM_RD:   begin o.mem_read = ~a; o.iord = 1'b1; end
      S_MEM_WB:   begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin o.mem_write = ~a; o.iord = 1'b1; end
      S_EXEC_R:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      S_R_WB:     begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      S_BRANCH:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = z; end
      S_ADDI_EX:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      S_ADDI_WB:  o.reg_write = 1'b1;
      S_JUMP:     begin o.pc_en = 1'b1; o.pc_source = 2'b10; end
      default:    o.st = p;
    endcase
    return o;
  endfunction

  task automatic push(state_e p, logic [5:0] o_op, logic r, logic z, logic a);
    rec_t x;
    x.op = o_op; x.ready = r; x.zero = z;
    x.exp = exp_out(p, r, z, a, m_err);
    plan.push_back(x);
  endtask

  // a memory step waiting w cycles; w >= T never completes and aborts
  task automatic push_mem(state_e p, int w, output bit aborted);
    aborted = 1'b0;
    if (w >= T) begin
      for (int k = 0; k < T; k++) push(p, 6'($urandom), 1'b0, 1'($urandom), k == T - 1);
      m_err   = 1'b1;
      aborted = 1'b1;
    end else begin
      for (int k = 0; k < w; k++) push(p, 6'($urandom), 1'b0, 1'($urandom), 1'b0);
      push(p, 6'($urandom), 1'b1, 1'($urandom), 1'b0);
    end
  endtask

  task automatic model_instr(logic [5:0] iop, logic z, int wf, int wm);
    bit ab;
    push_mem(S_FETCH, wf, ab);
    if (ab) return;
    push(S_DECODE, iop, 1'($urandom), 1'($urandom), 1'b0);
    case (iop)
      OP_RTYPE: begin
        push(S_EXEC_R, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        push(S_R_WB, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
      OP_ADDI: begin
        push(S_ADDI_EX, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        push(S_ADDI_WB, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
      OP_BEQ: push(S_BRANCH, 6'($urandom), 1'($urandom), z, 1'b0);
      OP_J:   push(S_JUMP, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      OP_LW: begin
        push(S_MEM_ADDR, iop, 1'($urandom), 1'($urandom), 1'b0);
        push_mem(S_MEM_RD, wm, ab);
        if (!ab) push(S_MEM_WB, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
      OP_SW: begin
        push(S_MEM_ADDR, iop, 1'($urandom), 1'($urandom), 1'b0);
        push_mem(S_MEM_WR, wm, ab);
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic probe_fetch();
    push(S_FETCH, 6'($urandom), 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic run_plan(int n);
    for (int i = 0; i < n && i < plan.size(); i++) begin
      op = plan[i].op; mem_ready = plan[i].ready; zero = plan[i].zero;
      @(negedge clk);
      seen.push_back(sample());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    plan.delete();
    seen.delete();
  endtask

  task automatic test_reset();
    obs_t o;
    mem_ready = 1'b1; zero = 1'b1; op = OP_LW;
    @(negedge clk);
    o = sample();
    checks++;
    if (o !== exp_out(S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", o, exp_out(S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    model_instr(OP_J, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL reset_then_j cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_lw();
    int wr;
    do_reset();
    model_instr(OP_LW, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    wr = 0;
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL lw cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
      if (seen[i].reg_write) wr++;
    end
    checks++;
    if (wr !== 1) begin
      errors++;
      $display("FAIL lw_reg_write_count: got %0d expected 1", wr);
    end
  endtask

  task automatic test_beq();
    do_reset();
    model_instr(OP_BEQ, 1'b1, 0, 0);
    model_instr(OP_BEQ, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL beq cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_fetch_wait();
    int pulses;
    do_reset();
    model_instr(OP_RTYPE, 1'b0, 3, 0);
    probe_fetch();
    run_plan(plan.size());
    pulses = 0;
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL fetch_wait cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
      if (seen[i].ir_write) pulses++;
    end
    checks++;
    if (pulses !== 1 || seen[3].ir_write !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait_pulse: got %0d pulses (cycle3=%b) expected 1 at cycle 3",
               pulses, seen[3].ir_write);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    model_instr(OP_SW, 1'b0, 0, 20);
    model_instr(OP_J, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_ready_wins();
    do_reset();
    model_instr(OP_LW, 1'b0, 15, 15);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL ready_wins cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    model_instr(6'b111111, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    do_reset();
    model_instr(OP_ADDI, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL illegal_then_reset cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_illegal_err();
    do_reset();
    model_instr(6'b111111, 1'b0, 0, 0);
    model_instr(OP_SW, 1'b0, 0, 1);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    model_instr(OP_LW, 1'b0, 0, 6);
    run_plan(5);
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 o = sample();
    checks++;
    if (o !== exp_out(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", o, exp_out(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    plan.delete();
    seen.delete();
    model_instr(OP_RTYPE, 1'b0, 0, 0);
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL reset_mid_rtype cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] iop;
    int wf, wm;
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    ops[4] = OP_ADDI;  ops[5] = OP_J;  ops[6] = 6'b111111;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      iop = ops[$urandom_range(0, 6)];
      if (iop == 6'b111111) iop = 6'($urandom_range(16, 31)) | 6'b100000;
      wf = ($urandom_range(0, 19) == 0) ? T + $urandom_range(0, 3) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 7) == 0) ? T - 1 + $urandom_range(0, 2) : $urandom_range(0, 4);
      model_instr(iop, 1'($urandom), wf, wm);
    end
    probe_fetch();
    run_plan(plan.size());
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, seen[i], plan[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_fetch_wait();
    test_timeout();
    test_ready_wins();
    test_illegal_err();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
